// File: rtl/flp_pkg.sv
// Shared floating-point format definitions for the integer-to-float datapath.
//   fp_fmt_t / fp_sp_t : packed {sign, exp, frac} layouts for the double and single presets
//   fp_bias()          : exponent bias for a given exponent field width
//   fp_bits()          : total encoded width for a given exponent/fraction split
//   max_int()          : compile-time helper for sizing internal vectors
package flp_pkg;

   localparam int DP_EXP_BITS = 11;
   localparam int DP_SIG_BITS = 52;
   localparam int SP_EXP_BITS = 8;
   localparam int SP_SIG_BITS = 23;

   typedef struct packed {
      logic                   sign;
      logic [DP_EXP_BITS-1:0] exp;
      logic [DP_SIG_BITS-1:0] frac;
   } fp_fmt_t;

   typedef struct packed {
      logic                   sign;
      logic [SP_EXP_BITS-1:0] exp;
      logic [SP_SIG_BITS-1:0] frac;
   } fp_sp_t;

   function automatic int fp_bias(input int exp_bits);
      return (1 << (exp_bits - 1)) - 1;
   endfunction

   function automatic int fp_bits(input int exp_bits, input int sig_bits);
      return 1 + exp_bits + sig_bits;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/leading_zero_count_param.sv
// Combinational leading-zero counter.
//   in_vec  : value to scan (MSB first)
//   count   : number of zeros above the leading one (WIDTH when in_vec is zero)
//   is_zero : in_vec has no set bit
module leading_zero_count_param #(
   parameter int WIDTH = 53
) (
   input  logic [WIDTH-1:0]             in_vec,
   output logic [$clog2(WIDTH+1)-1:0]   count,
   output logic                         is_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   // Scanning upwards lets the highest set bit win.
   always_comb begin
      count = CW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (in_vec[i]) count = CW'(WIDTH - 1 - i);
      end
   end

   assign is_zero = ~|in_vec;

endmodule

// File: rtl/int_to_flp_pipe.sv
// Three-stage multi-lane converter from centred residues mod q to IEEE-754 floats.
//   clk, rst_n            : clock, asynchronous active-low reset
//   q                     : modulus (changed only while the pipe is empty)
//   in_valid/in_ready     : input handshake; in_ready follows out_ready combinationally
//   in_data               : LANES residues, lane i at [i*LOGQ +: LOGQ]
//   scale_power           : signed power-of-two scale shared by all lanes
//   out_valid/out_ready   : output handshake with full back-pressure
//   out_data              : LANES packed {sign, exp, frac} results
//   out_ovf / out_unf     : per-lane saturation to infinity / flush to zero
module int_to_flp_pipe
   import flp_pkg::*;
#(
   parameter int LOGQ     = 54,
   parameter int LANES    = 2,
   parameter int EXP_BITS = DP_EXP_BITS,
   parameter int SIG_BITS = DP_SIG_BITS
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [LOGQ-1:0]                         q,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [LANES*LOGQ-1:0]                   in_data,
   input  logic [EXP_BITS:0]                       scale_power,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [LANES*(1+EXP_BITS+SIG_BITS)-1:0]  out_data,
   output logic [LANES-1:0]                        out_ovf,
   output logic [LANES-1:0]                        out_unf
);

   localparam int BIAS     = fp_bias(EXP_BITS);
   localparam int FP_BITS  = fp_bits(EXP_BITS, SIG_BITS);
   localparam int MAG_BITS = LOGQ - 1;
   localparam int TW       = MAG_BITS - 1;                  // normalised bits below the hidden one
   localparam int XW       = max_int(TW, SIG_BITS + 2);     // room for fraction + guard + sticky
   localparam int EW       = EXP_BITS + 3;
   localparam int LZW      = $clog2(MAG_BITS + 1);
   localparam logic signed [EW-1:0] E_MAX  = EW'((2 ** EXP_BITS) - 1);
   localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);

   logic                adv;
   logic                s1_valid, s2_valid;
   logic [EXP_BITS:0]   s1_scale, s2_scale;
   logic [LOGQ-1:0]     half_q;

   // The whole pipe moves together; bubbles travel as valid = 0.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign half_q   = q >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         s1_scale  <= '0;
         s2_scale  <= '0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
         s1_scale  <= scale_power;
         s2_scale  <= s1_scale;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LOGQ-1:0]        x;
      logic                   lift_sign;
      logic [MAG_BITS-1:0]    lift_mag;
      logic                   s1_sign;
      logic [MAG_BITS-1:0]    s1_mag;
      logic [LZW-1:0]         lz;
      logic                   mag_zero;
      logic                   s2_sign, s2_zero;
      logic [TW-1:0]          s2_tail;
      logic signed [EW-1:0]   s2_p;
      logic [XW-1:0]          tail_ext;
      logic [SIG_BITS-1:0]    frac_t, frac_r;
      logic                   guard, sticky, rnd_up, carry;
      logic signed [EW-1:0]   e_val;
      logic [FP_BITS-1:0]     fp_next, fp_q;
      logic                   ovf_next, unf_next, ovf_q, unf_q;

      assign x = in_data[gi*LOGQ +: LOGQ];

      // S1: centred lift
      always_comb begin
         lift_sign = x > half_q;
         lift_mag  = lift_sign ? MAG_BITS'(q - x) : MAG_BITS'(x);
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1_sign <= 1'b0;
            s1_mag  <= '0;
         end else if (adv) begin
            s1_sign <= lift_sign;
            s1_mag  <= lift_mag;
         end
      end

      // S2: normalise; only the bits below the hidden one are kept
      leading_zero_count_param #(.WIDTH(MAG_BITS)) u_lzc (
         .in_vec  (s1_mag),
         .count   (lz),
         .is_zero (mag_zero)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_tail <= '0;
            s2_p    <= '0;
         end else if (adv) begin
            s2_sign <= s1_sign;
            s2_zero <= mag_zero;
            s2_tail <= TW'(s1_mag << lz);
            s2_p    <= EW'(MAG_BITS - 1) - EW'(lz);
         end
      end

      // S3: round-to-nearest-even, exponent, saturation.
      // The tail is left-justified into XW bits so that narrow magnitudes get
      // zero guard/sticky and pass through exactly on the same path.
      always_comb begin
         tail_ext         = XW'(s2_tail) << (XW - TW);
         frac_t           = tail_ext[XW-1 -: SIG_BITS];
         guard            = tail_ext[XW-1-SIG_BITS];
         sticky           = |tail_ext[XW-2-SIG_BITS:0];
         rnd_up           = guard & (sticky | frac_t[0]);
         {carry, frac_r}  = {1'b0, frac_t} + (SIG_BITS+1)'(rnd_up);
         e_val            = {{2{s2_scale[EXP_BITS]}}, s2_scale} + s2_p + E_BIAS + EW'(carry);
         fp_next          = '0;
         ovf_next         = 1'b0;
         unf_next         = 1'b0;
         if (!s2_zero) begin
            if (e_val >= E_MAX) begin
               fp_next  = {s2_sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
               ovf_next = 1'b1;
            end else if (e_val <= 0) begin
               fp_next  = {s2_sign, {(FP_BITS-1){1'b0}}};
               unf_next = 1'b1;
            end else begin
               fp_next  = {s2_sign, e_val[EXP_BITS-1:0], frac_r};
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            fp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
         end else if (adv) begin
            fp_q  <= fp_next;
            ovf_q <= ovf_next;
            unf_q <= unf_next;
         end
      end

      assign out_data[gi*FP_BITS +: FP_BITS] = fp_q;
      assign out_ovf[gi]                     = ovf_q;
      assign out_unf[gi]                     = unf_q;
   end

endmodule

// File: tb/tb_int_to_flp_pipe.sv
// Bench for int_to_flp_pipe: a 4-lane double instance and a 2-lane single
// instance driven side by side, checked against an arithmetic reference model.
module tb_int_to_flp_pipe;

   localparam int DL = 4;
   localparam int DQ = 54;
   localparam int DE = 11;
   localparam int DS = 52;
   localparam int DF = 64;
   localparam int SL = 2;
   localparam int SQ = 30;
   localparam int SE = 8;
   localparam int SS = 23;
   localparam int SF = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [DQ-1:0]     d_q;
   logic              d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [DL*DQ-1:0]  d_in_data;
   logic [DE:0]       d_scale;
   logic [DL*DF-1:0]  d_out_data;
   logic [DL-1:0]     d_ovf, d_unf;

   logic [SQ-1:0]     s_q;
   logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [SL*SQ-1:0]  s_in_data;
   logic [SE:0]       s_scale;
   logic [SL*SF-1:0]  s_out_data;
   logic [SL-1:0]     s_ovf, s_unf;

   int_to_flp_pipe #(.LOGQ(DQ), .LANES(DL), .EXP_BITS(DE), .SIG_BITS(DS)) dut_d (
      .clk(clk), .rst_n(rst_n), .q(d_q), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_data(d_in_data), .scale_power(d_scale), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .out_data(d_out_data), .out_ovf(d_ovf), .out_unf(d_unf));

   int_to_flp_pipe #(.LOGQ(SQ), .LANES(SL), .EXP_BITS(SE), .SIG_BITS(SS)) dut_s (
      .clk(clk), .rst_n(rst_n), .q(s_q), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .scale_power(s_scale), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data), .out_ovf(s_ovf), .out_unf(s_unf));

   int n_chk = 0;
   int n_pass = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [255:0] data;
      logic [3:0]   ovf;
      logic [3:0]   unf;
      int unsigned  acc;
   } exp_t;

   exp_t dq[$];
   exp_t sq[$];

   task automatic check(input string name, input logic ok, input logic [255:0] got,
                        input logic [255:0] want);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, want);
   endtask

   // Reference conversion with plain integer arithmetic: returns {unf, ovf, word}.
   function automatic logic [65:0] ref_conv(input logic [63:0] q, input logic [63:0] x,
                                            input int scale, input int eb, input int sb);
      logic [63:0] m, keep, rem, half, fr, w;
      logic        sgn;
      int          p, e, sh;
      sgn = x > (q >> 1);
      m   = sgn ? q - x : x;
      if (m == 0) return '0;
      p = 0;
      while ((m >> (p + 1)) != 0) p++;
      if (p <= sb) begin
         keep = m << (sb - p);
      end else begin
         sh   = p - sb;
         keep = m >> sh;
         rem  = m - (keep << sh);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && keep[0])) keep = keep + 1;
         if (keep == (64'd1 << (sb + 1))) begin
            keep = keep >> 1;
            p++;
         end
      end
      fr = keep & ((64'd1 << sb) - 1);
      e  = scale + p + (2 ** (eb - 1) - 1);
      if (e >= 2 ** eb - 1)
         return {2'b01, (64'(sgn) << (eb + sb)) | (((64'd1 << eb) - 1) << sb)};
      if (e <= 0)
         return {2'b10, 64'(sgn) << (eb + sb)};
      w = (64'(sgn) << (eb + sb)) | (64'(e) << sb) | fr;
      return {2'b00, w};
   endfunction

   function automatic exp_t exp_d(input logic [DQ-1:0] q, input logic [DL*DQ-1:0] din,
                                  input logic [DE:0] sc);
      exp_t        e;
      logic [65:0] r;
      e.data = '0; e.ovf = '0; e.unf = '0; e.acc = 0;
      for (int i = 0; i < DL; i++) begin
         r = ref_conv(64'(q), 64'(din[i*DQ +: DQ]), int'($signed(sc)), DE, DS);
         e.data[i*DF +: DF] = r[DF-1:0];
         e.ovf[i] = r[64];
         e.unf[i] = r[65];
      end
      return e;
   endfunction

   function automatic exp_t exp_s(input logic [SQ-1:0] q, input logic [SL*SQ-1:0] din,
                                  input logic [SE:0] sc);
      exp_t        e;
      logic [65:0] r;
      e.data = '0; e.ovf = '0; e.unf = '0; e.acc = 0;
      for (int i = 0; i < SL; i++) begin
         r = ref_conv(64'(q), 64'(din[i*SQ +: SQ]), int'($signed(sc)), SE, SS);
         e.data[i*SF +: SF] = r[SF-1:0];
         e.ovf[i] = r[64];
         e.unf[i] = r[65];
      end
      return e;
   endfunction

   function automatic logic [63:0] rnd_res(input logic [63:0] q);
      logic [63:0] h;
      h = q >> 1;
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return 64'd1;
         2:       return h;
         3:       return h + 1;
         4:       return q - 1;
         default: return {$urandom, $urandom} % q;
      endcase
   endfunction

   // Double instance monitor / scoreboard
   logic [DL*DF-1:0] d_held;
   logic [2*DL-1:0]  d_hflg;
   logic             d_stalled = 1'b0;
   int unsigned      d_last_stall = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         dq.delete();
         d_stalled = 1'b0;
      end else begin
         if (d_stalled) begin
            check("d_stall_valid", d_out_valid == 1'b1, d_out_valid, 1);
            check("d_stall_hold", {d_out_data, d_ovf, d_unf} == {d_held, d_hflg},
                  d_out_data, d_held);
         end
         if (d_out_valid && d_out_ready) begin
            check("d_expected_pending", dq.size() != 0, dq.size(), 1);
            if (dq.size() != 0) begin
               e = dq.pop_front();
               check("d_data", d_out_data == e.data[DL*DF-1:0], d_out_data, e.data);
               check("d_flags", {d_ovf, d_unf} == {e.ovf, e.unf}, {d_ovf, d_unf}, {e.ovf, e.unf});
               if (d_last_stall < e.acc)
                  check("d_latency", cyc - e.acc == 3, cyc - e.acc, 3);
            end
         end
         d_stalled = d_out_valid && !d_out_ready;
         if (d_stalled) begin
            d_held = d_out_data;
            d_hflg = {d_ovf, d_unf};
            d_last_stall = cyc;
         end
         if (d_in_valid && d_in_ready) begin
            e = exp_d(d_q, d_in_data, d_scale);
            e.acc = cyc;
            dq.push_back(e);
         end
      end
   end

   // Single instance monitor / scoreboard
   logic [SL*SF-1:0] s_held;
   logic [2*SL-1:0]  s_hflg;
   logic             s_stalled = 1'b0;
   int unsigned      s_last_stall = 0;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sq.delete();
         s_stalled = 1'b0;
      end else begin
         if (s_stalled) begin
            check("s_stall_valid", s_out_valid == 1'b1, s_out_valid, 1);
            check("s_stall_hold", {s_out_data, s_ovf, s_unf} == {s_held, s_hflg},
                  s_out_data, s_held);
         end
         if (s_out_valid && s_out_ready) begin
            check("s_expected_pending", sq.size() != 0, sq.size(), 1);
            if (sq.size() != 0) begin
               e = sq.pop_front();
               check("s_data", s_out_data == e.data[SL*SF-1:0], s_out_data, e.data);
               check("s_flags", {s_ovf, s_unf} == {e.ovf[SL-1:0], e.unf[SL-1:0]},
                     {s_ovf, s_unf}, {e.ovf[SL-1:0], e.unf[SL-1:0]});
               if (s_last_stall < e.acc)
                  check("s_latency", cyc - e.acc == 3, cyc - e.acc, 3);
            end
         end
         s_stalled = s_out_valid && !s_out_ready;
         if (s_stalled) begin
            s_held = s_out_data;
            s_hflg = {s_ovf, s_unf};
            s_last_stall = cyc;
         end
         if (s_in_valid && s_in_ready) begin
            e = exp_s(s_q, s_in_data, s_scale);
            e.acc = cyc;
            sq.push_back(e);
         end
      end
   end

   task automatic drain(input string name);
      int n;
      n = 0;
      d_in_valid = 1'b0; s_in_valid = 1'b0;
      d_out_ready = 1'b1; s_out_ready = 1'b1;
      while ((dq.size() != 0 || sq.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      check({name, "_drain"}, dq.size() == 0 && sq.size() == 0, dq.size() + sq.size(), 0);
   endtask

   initial begin
      logic [65:0] r;
      logic [63:0] tmp;
      d_q = '0; d_in_valid = 1'b0; d_in_data = '0; d_scale = '0; d_out_ready = 1'b1;
      s_q = '0; s_in_valid = 1'b0; s_in_data = '0; s_scale = '0; s_out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_d_valid", d_out_valid == 1'b0, d_out_valid, 0);
      check("rst_d_data", d_out_data == '0 && d_ovf == '0 && d_unf == '0, d_out_data, 0);
      check("rst_d_in_ready", d_in_ready == 1'b1, d_in_ready, 1);
      check("rst_s_valid", s_out_valid == 1'b0, s_out_valid, 0);
      check("rst_s_data", s_out_data == '0 && s_ovf == '0 && s_unf == '0, s_out_data, 0);
      check("rst_s_in_ready", s_in_ready == 1'b1, s_in_ready, 1);
      @(negedge clk) rst_n = 1'b1;

      // Pin the reference model to hand-computed encodings
      r = ref_conv(64'd97, 64'd1, 0, DE, DS);
      check("model_one", r == {2'b00, 64'h3FF0000000000000}, r, {2'b00, 64'h3FF0000000000000});
      r = ref_conv(64'd97, 64'd96, 0, DE, DS);
      check("model_neg_one", r == {2'b00, 64'hBFF0000000000000}, r, {2'b00, 64'hBFF0000000000000});
      r = ref_conv(64'd97, 64'd3, -1, DE, DS);
      check("model_1p5", r == {2'b00, 64'h3FF8000000000000}, r, {2'b00, 64'h3FF8000000000000});
      r = ref_conv(64'd536870909, 64'd16777217, 0, SE, SS);
      check("model_tie_down", r == {2'b00, 64'h4B800000}, r, {2'b00, 64'h4B800000});
      r = ref_conv(64'd536870909, 64'd16777219, 0, SE, SS);
      check("model_tie_up", r == {2'b00, 64'h4B800002}, r, {2'b00, 64'h4B800002});
      r = ref_conv(64'd536870909, 64'd33554431, 0, SE, SS);
      check("model_carry", r == {2'b00, 64'h4C000000}, r, {2'b00, 64'h4C000000});
      r = ref_conv(64'd97, 64'd1, 1100, DE, DS);
      check("model_ovf", r == {2'b01, 64'h7FF0000000000000}, r, {2'b01, 64'h7FF0000000000000});
      r = ref_conv(64'd97, 64'd1, -1100, DE, DS);
      check("model_unf", r == {2'b10, 64'h0}, r, {2'b10, 64'h0});

      // Directed transactions (out_ready held high, so latency is checked too)
      d_q = 54'd97;
      s_q = 30'd536870909;
      @(posedge clk); #1;
      d_in_valid = 1'b1; d_in_data = {54'd3, 54'd0, 54'd96, 54'd1}; d_scale = '0;
      s_in_valid = 1'b1; s_in_data = {30'd16777219, 30'd16777217}; s_scale = '0;
      @(posedge clk); #1;
      d_in_data = {54'd48, 54'd49, 54'd3, 54'd3}; d_scale = -12'sd1;
      s_in_data = {30'd0, 30'd33554431};
      @(posedge clk); #1;
      d_in_data = {4{54'd1}}; d_scale = 12'sd1100;
      s_in_valid = 1'b0;
      @(posedge clk); #1;
      d_scale = -12'sd1100;
      @(posedge clk); #1;
      drain("directed");

      // Randomised traffic with random back-pressure
      for (int rnd = 0; rnd < 2; rnd++) begin
         tmp = {$urandom, $urandom};
         d_q = {1'b1, tmp[52:1], 1'b1};
         s_q = {1'b1, tmp[60:33], 1'b1};
         for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            d_in_valid  = ($urandom_range(0, 3) != 0);
            d_out_ready = ($urandom_range(0, 3) != 0);
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_out_ready = ($urandom_range(0, 2) != 0);
            for (int l = 0; l < DL; l++) d_in_data[l*DQ +: DQ] = DQ'(rnd_res(64'(d_q)));
            for (int l = 0; l < SL; l++) s_in_data[l*SQ +: SQ] = SQ'(rnd_res(64'(s_q)));
            d_scale = ($urandom_range(0, 1) == 1) ? 12'($urandom) : 12'($urandom_range(0, 80)) - 12'd40;
            s_scale = ($urandom_range(0, 1) == 1) ? 9'($urandom) : 9'($urandom_range(0, 40)) - 9'd20;
         end
         drain("random");
      end

      // Reset with three transactions in flight
      d_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         d_in_valid = 1'b1;
         for (int l = 0; l < DL; l++) d_in_data[l*DQ +: DQ] = DQ'(rnd_res(64'(d_q)));
         d_scale = '0;
      end
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      check("pre_rst_valid", d_out_valid == 1'b1, d_out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", d_out_valid == 1'b0, d_out_valid, 0);
      check("mid_rst_data", d_out_data == '0, d_out_data, 0);
      check("mid_rst_flags", d_ovf == '0 && d_unf == '0, {d_ovf, d_unf}, 0);
      check("mid_rst_in_ready", d_in_ready == 1'b1, d_in_ready, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      d_out_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("post_rst_idle", d_out_valid == 1'b0, d_out_valid, 0);
      d_in_valid = 1'b1;
      d_in_data = {54'd2, 54'd1, 54'd0, DQ'(d_q - 1)};
      d_scale = 12'sd4;
      @(posedge clk); #1;
      drain("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/int_to_flp_pipe.md
# int_to_flp_pipe

Multi-lane, parametrised converter from centred residues mod q to IEEE-754 binary floating point. It sits between the NTT/modular-arithmetic datapath and the floating-point FFT/decode datapath. Over the fixed double-only converter it adds:
- configurable precision;
- round-to-nearest-even;
- a signed per-transaction scale;
- overflow/underflow saturation;
- a valid/ready handshake with full back-pressure.

## Interface
Parameters:
- `LOGQ`, 54: residue width; q < 2^LOGQ, prime.
- `LANES`, 2: parallel conversions per transaction.
- `EXP_BITS`, 11: exponent field width (8 for single precision).
- `SIG_BITS`, 52: stored fraction width, hidden bit excluded (23 for single precision).
- Derived: `BIAS` = 2^(EXP_BITS-1)-1; `FP_BITS` = 1+EXP_BITS+SIG_BITS; `MAG_BITS` = LOGQ-1.

Ports:
- `clk`, in, 1: clock. One clock; all state on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `q`, in, LOGQ: modulus. Quasi-static; changes only while the pipe is empty.
- `in_valid`, in, 1: transaction offered.
- `in_ready`, out, 1: transaction accepted when `in_valid` and `in_ready` are both high.
- `in_data`, in, LANES*LOGQ: residues. Lane i occupies bits [i*LOGQ +: LOGQ]; each residue < q.
- `scale_power`, in, EXP_BITS+1: signed two's-complement power-of-two scale, captured with the transaction.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer accepts the result.
- `out_data`, out, LANES*FP_BITS: packed {sign, exponent, fraction} per lane, same lane order as `in_data`.
- `out_ovf`, out, LANES: lane saturated to infinity.
- `out_unf`, out, LANES: lane flushed to zero.

## Operation
Per lane, for residue x:
- **Centred lift.** `h` = floor(q/2).
  - x > h: sign = 1, m = q - x.
  - Otherwise: sign = 0, m = x.
  - m fits in MAG_BITS bits.
- **Zero.** m = 0 gives result all-zero, sign 0, no flags.
- **Normalise.** p = MAG_BITS-1 - lzc(m), the position of the leading one. Shift m left so the leading one sits at the MSB.
- **Round.** Applies only when MAG_BITS > SIG_BITS+1: round to nearest, ties to even, at SIG_BITS fraction bits.
  - If rounding carries out of the significand: fraction = 0, p += 1.
  - When MAG_BITS <= SIG_BITS+1: exact, zero-filled on the right.
- **Exponent.** E = scale_power + p + BIAS, computed signed with EXP_BITS+3 bits; no wrap-around permitted.
  - E >= 2^EXP_BITS-1: result = {sign, all-ones, 0} (infinity), `out_ovf` = 1.
  - E <= 0: result = {sign, 0, 0}, `out_unf` = 1. No subnormals.
- All lanes share one handshake and one `scale_power`.

## Timing
- **Stage 1 (S1):** register lift result (sign, m) and `scale_power`.
- **Stage 2 (S2):** LZC, normalise shift; register.
- **Stage 3 (S3):** round, exponent, saturation; register into the outputs.
- **Latency:** 3 cycles from accept to `out_valid` with no stall. Throughput is 1 transaction per cycle.
- **Advance condition:** `adv` = `out_ready` | ~`out_valid`.
  - The whole pipe shifts when `adv` is high, with bubbles carried as valid = 0.
  - `in_ready` = `adv`, combinational from `out_ready`.
- **Stall:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and flags hold stable and no input is accepted.
- **Reset:** every stage valid = 0. `out_valid`, `out_data`, `out_ovf` and `out_unf` are all 0. `in_ready` is 1 after reset (pipe empty).
- **Reset mid-operation:** in-flight transactions are discarded with no partial output. The first accepted input after release appears 3 cycles later.
- **Simultaneous accept and emit:** when `out_ready` = 1 and `in_valid` = 1 in the same cycle, one result leaves and one transaction enters.

## Structure
- Shared package `flp_pkg` holds:
  - the `fp_fmt_t` struct {sign, exp, frac}, parametrised via localparams;
  - the double/single presets (11/52, 8/23);
  - `BIAS` and `FP_BITS` helpers.
- One sub-module, `leading_zero_count_param` (combinational, width MAG_BITS, outputs count and is-zero). It is instantiated once per lane in S2.
- Lane logic is a generate loop; handshake control is a single shared instance.

## Test plan
- **Double exactness.** Defaults, q = 97, scale 0.
  - x = 1 -> 0x3FF0000000000000.
  - x = 96 -> 0xBFF0000000000000.
  - x = 0 -> 0.
  - x = 3 with scale -1 -> 0x3FF8000000000000 (1.5).
- **Single rounding.** LOGQ = 30, EXP_BITS = 8, SIG_BITS = 23, q = 536870909.
  - x = 16777217 -> 0x4B800000 (tie to even, down).
  - x = 16777219 -> 0x4B800002 (tie to even, up).
  - x = 33554431 -> 0x4C000000 (carry into exponent).
- **Saturation.** Defaults, x = 1.
  - scale 1100 -> 0x7FF0000000000000, `out_ovf` = 1.
  - scale -1100 -> 0, `out_unf` = 1.
- **Back-pressure.** Stream 10 transactions while toggling `out_ready` randomly -> outputs in order, none lost or duplicated, `out_data` stable during stalls.
- **Lanes and latency.** LANES = 4, distinct residues per lane -> each lane's result is in its own slot, exactly 3 cycles after accept with `out_ready` held at 1.
- **Reset mid-stream.** Pulse `rst_n` low with 3 transactions in flight -> all outputs 0 immediately (asynchronous), none emerge afterwards, `in_ready` = 1.
